// File: rtl/uk101_pkg.sv
// Shared UK101 capture definitions: FSM state encoding, special character codes,
// and the text-filter predicate used when CAPTURE_TEXT_FILTER_EN is defined.
package uk101_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    UPLOAD  = 2'd2,
    CLEAR   = 2'd3
  } cap_state_t;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] RD_PAD = 8'h00;

  // Bytes that carry no printable content in a saved text file.
  function automatic logic is_ctrl_drop(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_NUL) || (b == CH_DEL);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// No reset on the array or read register so block-RAM inference is possible.
module capture_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_sys,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Write when enabled; read data is always one cycle behind raddr.
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/acia_tx_capture.sv
// Captures bytes written to the ACIA transmit register into a buffer that the
// HPS can later read back as a file. Optional macro CAPTURE_TEXT_FILTER_EN drops
// CR/NUL/DEL and strips bit 7 from stored bytes; undefined stores bytes raw.
module acia_tx_capture
  import uk101_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_strobe,
  input  logic             capture_en,
  input  logic             clear,
  input  logic             ioctl_upload,
  input  logic             ioctl_rd,
  input  logic [15:0]      ioctl_addr,
  output logic [7:0]       ioctl_din,
  output logic             ioctl_wait,
  output logic [LEN_W-1:0] cap_len,
  output logic             lost
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  cap_state_t state, state_nxt;
  logic       cap_en_q;
  logic       cap_rise;
  logic       take_clear;
  logic       full;
  logic       keep;
  logic [7:0] wr_byte;
  logic       wr_en;
  logic       set_lost;
  logic       rd_go;
  logic       rd_wait_q;
  logic       oob_q;
  logic [7:0] ram_rdata;

  assign cap_rise   = capture_en & ~cap_en_q;
  assign take_clear = clear && (state != UPLOAD);
  assign full       = (cap_len == LEN_FULL);
  assign rd_go      = ioctl_rd && (state == UPLOAD);

  // State register and capture_en edge history.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      cap_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cap_en_q <= capture_en;
    end
  end

  // Next state: clear beats upload outside UPLOAD; a fresh capture_en edge clears first.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (clear || cap_rise) state_nxt = CLEAR;
        else if (ioctl_upload) state_nxt = UPLOAD;
        else if (capture_en)   state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (clear)             state_nxt = CLEAR;
        else if (ioctl_upload) state_nxt = UPLOAD;
        else if (!capture_en)  state_nxt = IDLE;
      end
      UPLOAD: begin
        if (!ioctl_upload) state_nxt = IDLE;
      end
      CLEAR: begin
        if (clear)             state_nxt = CLEAR;
        else if (ioctl_upload) state_nxt = UPLOAD;
        else if (capture_en)   state_nxt = CAPTURE;
        else                   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decide the fate of a strobed byte: store, drop silently, or drop and flag lost.
  always_comb begin
    wr_en    = 1'b0;
    set_lost = 1'b0;
`ifdef CAPTURE_TEXT_FILTER_EN
    keep    = !is_ctrl_drop(tx_data);
    wr_byte = {1'b0, tx_data[6:0]};
`else
    keep    = 1'b1;
    wr_byte = tx_data;
`endif
    if (tx_strobe && !take_clear) begin
      case (state)
        CAPTURE: begin
          if (keep) begin
            if (full) set_lost = 1'b1;
            else      wr_en    = 1'b1;
          end
        end
        UPLOAD, CLEAR: set_lost = 1'b1;
        default: ;
      endcase
    end
  end

  // Length counter and sticky lost flag; a drop during CLEAR still flags lost.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cap_len <= '0;
      lost    <= 1'b0;
    end else if (state == CLEAR) begin
      cap_len <= '0;
      lost    <= set_lost;
    end else begin
      if (wr_en)    cap_len <= cap_len + LEN_W'(1);
      if (set_lost) lost    <= 1'b1;
    end
  end

  capture_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_sys (clk_sys),
    .we      (wr_en),
    .waddr   (cap_len[ADDR_W-1:0]),
    .wdata   (wr_byte),
    .raddr   (ioctl_addr[ADDR_W-1:0]),
    .rdata   (ram_rdata)
  );

  // Read pipeline: wait during the RAM access cycle, data lands as wait drops.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_wait_q <= 1'b0;
      oob_q     <= 1'b0;
      ioctl_din <= RD_PAD;
    end else begin
      rd_wait_q <= rd_go;
      if (rd_go)     oob_q     <= (32'(ioctl_addr) >= 32'(cap_len));
      if (rd_wait_q) ioctl_din <= oob_q ? RD_PAD : ram_rdata;
    end
  end

  // Gated by reset so a read aborted by reset never shows a wait pulse.
  assign ioctl_wait = rd_wait_q & ~reset;

endmodule

// File: tb/tb_acia_tx_capture.sv
// Directed bench for acia_tx_capture (ADDR_W=4). A queue-based model of the
// stored bytes is checked every cycle; literal values pin the key scenarios.
module tb_acia_tx_capture;

  localparam int AW    = 4;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_strobe = 1'b0;
  logic          capture_en = 1'b0;
  logic          clear = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [15:0]   ioctl_addr = 16'h0000;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [LW-1:0] cap_len;
  logic          lost;

  acia_tx_capture #(.ADDR_W(AW)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_strobe    (tx_strobe),
    .capture_en   (capture_en),
    .clear        (clear),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .cap_len      (cap_len),
    .lost         (lost)
  );

  always #5 clk_sys = ~clk_sys;

  // Model: stored bytes as a queue, plus lost/wait/din and a coarse mode
  // (0 idle, 1 capturing, 2 uploading) known from the stimulus sequence.
  byte unsigned m_mem[$];
  bit           m_lost = 1'b0;
  logic [7:0]   m_din = 8'h00;
  bit           m_wait = 1'b0;
  int           mode = 0;
  bit           chk_en = 1'b0;
  int           n_chk = 0;
  int           n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("cmp_cap_len", 32'(cap_len), m_mem.size());
      chk("cmp_lost", 32'(lost), 32'(m_lost));
      chk("cmp_wait", 32'(ioctl_wait), 32'(m_wait));
      chk("cmp_din", 32'(ioctl_din), 32'(m_din));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    bit         drop;
    logic [7:0] s;
    drop = 1'b0;
    s    = b;
`ifdef CAPTURE_TEXT_FILTER_EN
    drop = (b inside {8'h0D, 8'h00, 8'h7F});
    s    = b & 8'h7F;
`endif
    tx_data = b; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    if (mode == 1 && !drop) begin
      if (m_mem.size() == DEPTH) m_lost = 1'b1;
      else m_mem.push_back(s);
    end else if (mode == 2) begin
      m_lost = 1'b1;
    end
  endtask

  task automatic start_capture();
    chk_en = 1'b0;
    capture_en = 1'b1;
    tick(); tick();
    m_mem.delete(); m_lost = 1'b0; mode = 1;
    chk_en = 1'b1;
  endtask

  task automatic stop_capture();
    capture_en = 1'b0;
    tick();
    mode = 0;
  endtask

  task automatic upload_on();
    ioctl_upload = 1'b1;
    tick();
    mode = 2;
  endtask

  task automatic upload_off();
    ioctl_upload = 1'b0;
    tick();
    mode = 0;
    if (capture_en) begin
      tick();
      mode = 1;
    end
  endtask

  task automatic rd(input int a, input logic [7:0] lit);
    logic [7:0] e;
    e = (a < m_mem.size()) ? 8'(m_mem[a]) : 8'h00;
    ioctl_addr = 16'(a); ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    m_wait = (mode == 2);
    chk("rd_wait_hi", 32'(ioctl_wait), 32'(mode == 2));
    tick();
    m_wait = 1'b0;
    if (mode == 2) m_din = e;
    chk("rd_wait_lo", 32'(ioctl_wait), 0);
    if (mode == 2) chk("rd_data", 32'(ioctl_din), 32'(lit));
  endtask

  byte unsigned v3[5] = '{8'h41, 8'h0D, 8'h0A, 8'h00, 8'hC2};

  initial begin
    // reset state
    tick(); tick();
    chk("rst_len", 32'(cap_len), 0);
    chk("rst_lost", 32'(lost), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_din", 32'(ioctl_din), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // basic capture and upload with persistence through IDLE
    start_capture();
    strobe(8'h41); strobe(8'h42); strobe(8'h43);
    chk("abc_len", 32'(cap_len), 3);
    stop_capture();
    upload_on();
    rd(0, 8'h41); rd(1, 8'h42); rd(2, 8'h43); rd(3, 8'h00);
    upload_off();

    // text filter or raw storage
    start_capture();
    foreach (v3[i]) strobe(8'(v3[i]));
`ifdef CAPTURE_TEXT_FILTER_EN
    chk("filt_len", 32'(cap_len), 3);
    stop_capture();
    upload_on();
    rd(0, 8'h41); rd(1, 8'h0A); rd(2, 8'h42); rd(3, 8'h00);
`else
    chk("raw_len", 32'(cap_len), 5);
    stop_capture();
    upload_on();
    rd(0, 8'h41); rd(1, 8'h0D); rd(2, 8'h0A); rd(3, 8'h00); rd(4, 8'hC2); rd(5, 8'h00);
`endif
    upload_off();

    // overflow: 17 strobes into 16 entries
    start_capture();
    for (int i = 0; i < 17; i++) strobe(8'(8'h30 + i));
    chk("full_len", 32'(cap_len), 16);
    chk("full_lost", 32'(lost), 1);
    stop_capture();
    upload_on();
    rd(15, 8'h3F); rd(16, 8'h00); rd(0, 8'h30); rd(256, 8'h00);
    upload_off();

    // strobe and clear during upload, resume capture afterwards
    start_capture();
    strobe(8'h11); strobe(8'h22);
    upload_on();
    strobe(8'h55);
    chk("upl_lost", 32'(lost), 1);
    chk("upl_len", 32'(cap_len), 2);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("upl_clear_len", 32'(cap_len), 2);
    rd(0, 8'h11); rd(1, 8'h22); rd(2, 8'h00);
    upload_off();
    strobe(8'h33);
    chk("resume_len", 32'(cap_len), 3);
    stop_capture();

    // clear coincident with a strobe
    start_capture();
    strobe(8'h10);
    chk_en = 1'b0;
    tx_data = 8'h66; tx_strobe = 1'b1; clear = 1'b1;
    tick();
    tx_strobe = 1'b0; clear = 1'b0;
    tick();
    m_mem.delete(); m_lost = 1'b0;
    chk_en = 1'b1;
    chk("clr_len", 32'(cap_len), 0);
    chk("clr_lost", 32'(lost), 0);
    strobe(8'h77);
    chk("after_clr_len", 32'(cap_len), 1);
    stop_capture();
    strobe(8'h88);
    chk("idle_strobe_lost", 32'(lost), 0);
    chk("idle_strobe_len", 32'(cap_len), 1);
    upload_on();
    rd(1, 8'h00); rd(0, 8'h77);
    upload_off();
    rd(0, 8'h00);
    chk("idle_rd_din", 32'(ioctl_din), 32'h77);

    // reset one cycle after a read request
    upload_on();
    ioctl_addr = 16'h0000; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0; reset = 1'b1; ioctl_upload = 1'b0; m_wait = 1'b0;
    #1;
    chk("rst_rd_wait0", 32'(ioctl_wait), 0);
    tick();
    m_mem.delete(); m_lost = 1'b0; m_din = 8'h00; mode = 0;
    chk("rst_rd_len", 32'(cap_len), 0);
    chk("rst_rd_lost", 32'(lost), 0);
    chk("rst_rd_din", 32'(ioctl_din), 0);
    reset = 1'b0;
    tick();
    chk("rst_rd_wait1", 32'(ioctl_wait), 0);
    rd(0, 8'h00);
    strobe(8'h5A);
    chk("post_rst_lost", 32'(lost), 0);
    chk("post_rst_len", 32'(cap_len), 0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
